// File: rtl/kd_point_router.sv
// Walks one point at a time down a kd-tree held in heap order and reports the leaf it lands on.
// The captured point is broadcast to the PE array; one level costs a fetch cycle plus a compare cycle.
module kd_point_router #(
    parameter int dim         = 3,
    parameter int data_range  = 255,
    parameter int max_depth   = 16,
    parameter int dim_size    = $clog2(data_range),
    parameter int center_size = dim * dim_size,
    parameter int depth_size  = $clog2(max_depth),
    parameter int addr_size   = max_depth
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   en,
    input  logic [depth_size-1:0]  levels,
    input  logic                   point_valid,
    output logic                   point_ready,
    input  logic [center_size-1:0] point_in,
    output logic [center_size-1:0] point_out,
    output logic                   receive_point,
    output logic [addr_size-1:0]   node_addr,
    input  logic [center_size-1:0] node_center,
    output logic [depth_size-1:0]  depth,
    output logic                   next_level,
    output logic                   go_left,
    output logic                   inc,
    output logic                   leaf_valid,
    input  logic                   leaf_ready,
    output logic [addr_size-1:0]   leaf_addr
);

    localparam int axis_size = (dim > 1) ? $clog2(dim) : 1;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LOAD    = 3'd1,
        FETCH   = 3'd2,
        COMPARE = 3'd3,
        INC     = 3'd4,
        OUT     = 3'd5
    } state_t;

    state_t                 state, state_nxt;
    logic                   started;
    logic [center_size-1:0] point_q;
    logic [addr_size-1:0]   addr_q;
    logic [depth_size-1:0]  depth_q;
    logic [depth_size-1:0]  last_depth;
    logic [axis_size-1:0]   axis_q;
    logic                   go_left_q;
    logic [addr_size-1:0]   leaf_addr_q;

    logic                   accept;
    logic                   at_leaf;
    logic                   go_left_nxt;

    // Index of the deepest level to visit: 0 behaves as one level, oversize requests clamp.
    function automatic logic [depth_size-1:0] last_level(input logic [depth_size-1:0] lv);
        if (lv == '0)
            return '0;
        else if (32'(lv) > max_depth)
            return depth_size'(max_depth - 1);
        else
            return lv - 1'b1;
    endfunction

    function automatic logic [dim_size-1:0] axis_coord(input logic [center_size-1:0] v,
                                                       input logic [axis_size-1:0]   a);
        axis_coord = '0;
        for (int k = 0; k < dim; k++)
            if (int'(a) == k)
                axis_coord = v[k*dim_size +: dim_size];
    endfunction

    assign accept      = (state == IDLE) && started && point_valid;
    assign at_leaf     = (depth_q == last_depth);
    assign go_left_nxt = axis_coord(point_q, axis_q) < axis_coord(node_center, axis_q);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            state <= IDLE;
        else if (en)
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = LOAD;
            LOAD:    state_nxt = FETCH;
            FETCH:   state_nxt = COMPARE;
            COMPARE: state_nxt = at_leaf ? INC : FETCH;
            INC:     state_nxt = OUT;
            OUT:     if (leaf_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Strobes decode the state register and are masked while frozen so a resumed walk still fires them once.
    always_comb begin
        point_ready   = (state == IDLE) && started && en;
        receive_point = (state == LOAD) && en;
        next_level    = (state == COMPARE) && !at_leaf && en;
        inc           = (state == INC) && en;
        leaf_valid    = (state == OUT);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            started     <= 1'b0;
            point_q     <= '0;
            addr_q      <= '0;
            depth_q     <= '0;
            last_depth  <= '0;
            axis_q      <= '0;
            go_left_q   <= 1'b0;
            leaf_addr_q <= '0;
        end else if (en) begin
            started <= 1'b1;
            case (state)
                IDLE: begin
                    if (accept) begin
                        point_q    <= point_in;
                        addr_q     <= '0;
                        depth_q    <= '0;
                        axis_q     <= '0;
                        last_depth <= last_level(levels);
                    end
                end
                COMPARE: begin
                    go_left_q <= go_left_nxt;
                    if (!at_leaf) begin
                        addr_q  <= {addr_q[addr_size-2:0], 1'b0}
                                   + (go_left_nxt ? addr_size'(1) : addr_size'(2));
                        depth_q <= depth_q + 1'b1;
                        axis_q  <= (axis_q == axis_size'(dim - 1)) ? '0 : axis_q + 1'b1;
                    end
                end
                INC:     leaf_addr_q <= addr_q;
                default: ;
            endcase
        end
    end

    assign point_out = point_q;
    assign node_addr = addr_q;
    assign depth     = depth_q;
    assign go_left   = go_left_q;
    assign leaf_addr = leaf_addr_q;

endmodule

// File: tb/tb_kd_point_router.sv
// Directed bench for kd_point_router: fixed three-node tree, hand-computed strobe timelines per walk.
module tb_kd_point_router;

    logic        clk;
    logic        rst;
    logic        en;
    logic [3:0]  levels;
    logic        point_valid;
    logic        point_ready;
    logic [23:0] point_in;
    logic [23:0] point_out;
    logic        receive_point;
    logic [15:0] node_addr;
    logic [23:0] node_center;
    logic [3:0]  depth;
    logic        next_level;
    logic        go_left;
    logic        inc;
    logic        leaf_valid;
    logic        leaf_ready;
    logic [15:0] leaf_addr;

    int tests = 0;
    int fails = 0;

    logic [31:0] rp_h, nl_h, inc_h, lv_h, gl_h;
    logic [15:0] addr_h [0:31];

    // Points packed as {z, y, x}
    localparam logic [23:0] P1 = {8'd10, 8'd80, 8'd50};
    localparam logic [23:0] P2 = {8'd0, 8'd0, 8'd200};
    localparam logic [23:0] P3 = {8'd0, 8'd0, 8'd50};

    kd_point_router dut (
        .clk           (clk),
        .rst           (rst),
        .en            (en),
        .levels        (levels),
        .point_valid   (point_valid),
        .point_ready   (point_ready),
        .point_in      (point_in),
        .point_out     (point_out),
        .receive_point (receive_point),
        .node_addr     (node_addr),
        .node_center   (node_center),
        .depth         (depth),
        .next_level    (next_level),
        .go_left       (go_left),
        .inc           (inc),
        .leaf_valid    (leaf_valid),
        .leaf_ready    (leaf_ready),
        .leaf_addr     (leaf_addr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Tree: node0 x=100, node1 y=50, node4 z=10; the center arrives one cycle after the address.
    function automatic logic [23:0] center_of(input logic [15:0] a);
        case (a)
            16'd0:   return {8'd0, 8'd0, 8'd100};
            16'd1:   return {8'd0, 8'd50, 8'd0};
            16'd4:   return {8'd10, 8'd0, 8'd0};
            default: return 24'd0;
        endcase
    endfunction

    always @(posedge clk) node_center <= center_of(node_addr);

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Records per-cycle outputs; cycle 1 is the cycle after the accepting edge.
    task automatic walk(input int ncyc, input int off_at, input int on_at);
        rp_h = '0; nl_h = '0; inc_h = '0; lv_h = '0; gl_h = '0;
        for (int c = 1; c <= ncyc; c++) begin
            step();
            if (c == 1) point_valid = 1'b0;
            rp_h[c]   = receive_point;
            nl_h[c]   = next_level;
            inc_h[c]  = inc;
            lv_h[c]   = leaf_valid;
            gl_h[c]   = go_left;
            addr_h[c] = node_addr;
            if (c == off_at) en = 1'b0;
            if (c == on_at)  en = 1'b1;
        end
    endtask

    initial begin
        rst = 1'b1; en = 1'b1; levels = 4'd3; point_valid = 1'b0;
        point_in = '0; leaf_ready = 1'b0;
        #1 rst = 1'b0;
        #1;
        check("rst_async_ready", point_ready, 0);
        check("rst_async_point_out", point_out, 0);
        check("rst_async_addr", node_addr, 0);
        step(); step();
        check("rst_held_strobes", {receive_point, next_level, inc, leaf_valid, go_left}, 0);
        check("rst_held_leaf_addr", leaf_addr, 0);
        check("rst_held_depth", depth, 0);
        rst = 1'b1;
        check("rst_release_no_ready_yet", point_ready, 0);
        step();
        check("rst_release_ready", point_ready, 1);

        // Three levels: left at root, right at node1, tie at node4 goes right.
        levels = 4'd3; point_in = P1; point_valid = 1'b1;
        walk(10, -1, -1);
        check("l3_receive_point", rp_h, 32'h2);
        check("l3_next_level", nl_h, 32'h28);
        check("l3_inc", inc_h, 32'h100);
        check("l3_leaf_valid", lv_h, 32'h600);
        check("l3_go_left_trace", gl_h, 32'h30);
        check("l3_addr_c3", addr_h[3], 0);
        check("l3_addr_c4", addr_h[4], 1);
        check("l3_addr_c6", addr_h[6], 4);
        check("l3_point_out", point_out, P1);
        check("l3_leaf_addr", leaf_addr, 4);
        check("l3_depth", depth, 2);

        // Backpressure with a second point waiting.
        levels = 4'd0; point_in = P2; point_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            check("bp_leaf_valid", leaf_valid, 1);
            check("bp_leaf_addr", leaf_addr, 4);
            check("bp_go_left", go_left, 0);
            check("bp_point_ready", point_ready, 0);
            check("bp_no_accept", receive_point, 0);
        end
        leaf_ready = 1'b1;
        step();
        check("bp_release_leaf_valid", leaf_valid, 0);
        check("bp_release_ready", point_ready, 1);
        check("bp_release_no_accept_yet", receive_point, 0);
        leaf_ready = 1'b0;

        // levels=0 runs as a single level: 200 >= 100 goes right at the root.
        walk(6, -1, -1);
        check("l0_receive_point", rp_h, 32'h2);
        check("l0_next_level", nl_h, 32'h0);
        check("l0_inc", inc_h, 32'h10);
        check("l0_leaf_valid", lv_h, 32'h60);
        check("l0_leaf_addr", leaf_addr, 0);
        check("l0_go_left", go_left, 0);
        check("l0_point_out", point_out, P2);
        leaf_ready = 1'b1; step(); leaf_ready = 1'b0;

        // Freeze for three edges while fetching depth 1; everything after shifts by three cycles.
        levels = 4'd3; point_in = P1; point_valid = 1'b1;
        walk(13, 4, 7);
        check("en_receive_point", rp_h, 32'h2);
        check("en_next_level", nl_h, 32'h108);
        check("en_inc", inc_h, 32'h800);
        check("en_leaf_valid", lv_h, 32'h3000);
        check("en_addr_frozen", addr_h[6], 1);
        check("en_addr_c9", addr_h[9], 4);
        check("en_leaf_addr", leaf_addr, 4);
        leaf_ready = 1'b1; step(); leaf_ready = 1'b0;

        // Asynchronous reset between edges while comparing at depth 1.
        levels = 4'd3; point_in = P1; point_valid = 1'b1;
        walk(5, -1, -1);
        check("ar_pre_next_level", nl_h[5], 1);
        check("ar_pre_addr", node_addr, 1);
        #2 rst = 1'b0;
        #1;
        check("ar_point_out", point_out, 0);
        check("ar_node_addr", node_addr, 0);
        check("ar_go_left", go_left, 0);
        check("ar_next_level", next_level, 0);
        check("ar_leaf_addr", leaf_addr, 0);
        check("ar_depth", depth, 0);
        step();
        rst = 1'b1;
        walk(8, -1, -1);
        check("ar_no_inc", inc_h, 0);
        check("ar_no_leaf_valid", lv_h, 0);
        check("ar_no_receive", rp_h, 0);
        check("ar_ready_after", point_ready, 1);

        // New point after reset: single level, 50 < 100 goes left.
        levels = 4'd1; point_in = P3; point_valid = 1'b1;
        walk(6, -1, -1);
        check("post_receive_point", rp_h, 32'h2);
        check("post_next_level", nl_h, 32'h0);
        check("post_inc", inc_h, 32'h10);
        check("post_leaf_valid", lv_h, 32'h60);
        check("post_go_left", go_left, 1);
        check("post_leaf_addr", leaf_addr, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
